bcd_to_bin: RTL
===============

// Module: bcd_to_bin
// PURPOSE
// - Sequential BCD-to-binary converter (reverse double-dabble): shift right, subtract 3.
// - Converts an M-bit packed BCD value to an N-bit unsigned binary value in N clock cycles.
// - Pairs with the binary-to-BCD converter on the display/keypad datapath.
// - Uses the same new_data/new_ack/done handshake.
// PARAMETERS
// - N  16  Bit width of binary result; also the number of conversion cycles
// - M  20  Bit width of BCD input; must be a multiple of 4; m = M/4 digits, digit 0 = [3:0]
// PORTS
// - clk       in   1    Global clock, rising edge
// - rst_n     in   1    Global reset, asynchronous, active-low
// - data_in   in   M    Packed BCD value to convert
// - new_data  in   1    Request: data_in valid, start conversion
// - data_out  out  N    Binary result register; changes only on completion
// - done      out  1    High while in DONE; data_out and flags valid
// - new_ack   out  1    Combinational; high when new_data is accepted this cycle
// - err_digit out  1    Last accepted input had a nibble > 9
// - overflow  out  1    Last converted value exceeded 2^N-1
// BEHAVIOUR
// - Reset (async assert, sync release):
//   - state=IDLE; cnt, BCD shift reg, BIN shift reg, data_out, err_digit, overflow = 0.
//   - done = new_ack = 0.
// - FSM states IDLE, CONVERSION, DONE:
//   - IDLE: new_data=1 -> new_ack=1 same cycle. Latch data_in into BCD reg and clear BIN reg.
//     - All nibbles <= 9 -> CONVERSION.
//     - Any nibble > 9 -> DONE directly. Set data_out=0, err_digit=1, overflow=0.
//   - CONVERSION: one step per cycle.
//     - Step: shift {BCD,BIN} right by 1; BCD[0] enters BIN[N-1].
//     - Then each shifted digit >= 8 gets -3 (all digits in parallel, same cycle).
//     - cnt (width $clog2(N)) counts 0..N-1; the step at cnt==N-1 is the last.
//     - At that edge -> DONE, cnt cleared.
//     - data_out <= stepped BIN value; overflow <= (stepped BCD value != 0); err_digit <= 0.
//     - new_data is ignored: new_ack=0 and no request is queued.
//   - DONE: done=1. new_data=1 -> new_ack=1, latch as in IDLE (incl. invalid-digit path).
//     - done drops at the next edge unless the invalid path re-enters DONE.
// - Latency: accept edge T0 -> data_out/flags update and done rises at edge T0+N.
//   - Invalid input: done at edge T0+1.
//   - Back-to-back: next request may be accepted in the first DONE cycle.
//   - Worst-case throughput: one conversion per N+1 cycles.
// - data_out, err_digit and overflow hold their values until the next completion.
//   - They are not cleared by accepting a new request.
// - Overflow: data_out = true value mod 2^N. Example: N=16, 0x65536 -> 0x0000, overflow=1.
// - Reset mid-conversion: immediate return to the reset values; the partial result is discarded.
// - Simultaneous events:
//   - new_data in DONE and reset asserted -> reset wins.
//   - new_data held high continuously -> accepted only in IDLE/DONE cycles.
// - Digit correction uses M-wide combinational logic; there are no multipliers.
// TESTING
// - Reset, then BCD 0x00000 -> done at T0+16, data_out=0x0000, err=0, ovf=0.
// - BCD 0x65535 -> data_out=0xFFFF, ovf=0, done exactly 16 cycles after the ack edge.
// - BCD 0x65536 -> ovf=1, data_out=0x0000.
// - BCD 0x99999 -> ovf=1, data_out=0x869F.
// - BCD 0x1A234 -> new_ack=1, done at T0+1, err_digit=1, data_out=0x0000.
// - Next valid 0x00042 -> err_digit=0, data_out=0x002A.
// - Pulse new_data at cycle 5 of a conversion -> new_ack=0, result unaffected.
// - Request in the DONE cycle -> acked; old data_out holds until the new done.
// - Assert rst_n=0 at cycle 8 of conversion -> all outputs 0 asynchronously.
//   - After release, state is IDLE and data_in 0x12345 -> data_out=0x3039.
// - 1000 random valid BCD values, back-to-back -> data_out matches the integer model.
//   - ovf matches (value > 65535) for every conversion.

Source files
------------

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one bit per clock.
// The new_data/new_ack/done handshake matches the binary-to-BCD converter.
module bcd_to_bin #(
    parameter int N = 16,
    parameter int M = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [M-1:0] data_in,
    input  logic         new_data,
    output logic [N-1:0] data_out,
    output logic         done,
    output logic         new_ack,
    output logic         err_digit,
    output logic         overflow
);
    localparam int D  = M / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CONVERSION, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [M-1:0]  bcd, bcd_shift, bcd_step;
    logic [N-1:0]  bin, bin_step;
    logic [D-1:0]  bad_nib;
    logic          bad_digit, last_step;

    // Shift {bcd,bin} right by one; the bit leaving the BCD side enters the binary MSB.
    assign bcd_shift = {1'b0, bcd[M-1:1]};
    assign bin_step  = {bcd[0], bin[N-1:1]};

    // Any digit that received a carry from above (>= 8 after the shift) gets -3.
    for (genvar g = 0; g < D; g++) begin : g_digit
        assign bcd_step[4*g +: 4] = bcd_shift[4*g+3] ? bcd_shift[4*g +: 4] - 4'd3
                                                     : bcd_shift[4*g +: 4];
        assign bad_nib[g] = data_in[4*g +: 4] > 4'd9;
    end

    assign bad_digit = |bad_nib;
    assign last_step = (cnt == CW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        new_ack   = 1'b0;
        done      = (state == DONE);
        case (state)
            IDLE, DONE: begin
                if (new_data && rst_n) begin
                    new_ack   = 1'b1;
                    state_nxt = bad_digit ? DONE : CONVERSION;
                end else begin
                    state_nxt = IDLE;
                end
            end
            CONVERSION: if (last_step) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            bcd       <= '0;
            bin       <= '0;
            data_out  <= '0;
            err_digit <= 1'b0;
            overflow  <= 1'b0;
        end else if (new_ack) begin
            bcd <= data_in;
            bin <= '0;
            cnt <= '0;
            if (bad_digit) begin
                data_out  <= '0;
                err_digit <= 1'b1;
                overflow  <= 1'b0;
            end
        end else if (state == CONVERSION) begin
            bcd <= bcd_step;
            bin <= bin_step;
            if (last_step) begin
                cnt       <= '0;
                data_out  <= bin_step;
                overflow  <= |bcd_step;
                err_digit <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule
